// File: rtl/micro_sequencer.sv
// Microprogram sequencer: owns the microPC, picks next/jump/decode address each cycle, stalls on memory access.
// Zero-latency stall output; one-cycle address update; holds until memory ack, debug halt release or reset.
module micro_sequencer #(
  parameter int                              MICRO_SEQUENCER_ADDR       = 11,
  parameter int                              MICRO_SEQUENCER_TIMEOUT    = 15,
  parameter logic [MICRO_SEQUENCER_ADDR-1:0] MICRO_SEQUENCER_FAULT_ADDR = 11'h7FF
) (
  input  logic                            MICRO_SEQUENCER_CLOCK_50,
  input  logic                            MICRO_SEQUENCER_ResetInLow_In,
  input  logic [1:0]                      MICRO_SEQUENCER_Tipo_InBus,
  input  logic [MICRO_SEQUENCER_ADDR-1:0] MICRO_SEQUENCER_JumpAddr_InBus,
  input  logic [1:0]                      MICRO_SEQUENCER_Op_InBus,
  input  logic [5:0]                      MICRO_SEQUENCER_Op3_InBus,
  input  logic                            MICRO_SEQUENCER_MemRd_In,
  input  logic                            MICRO_SEQUENCER_MemWr_In,
  input  logic                            MICRO_SEQUENCER_MemAck_In,
  input  logic                            MICRO_SEQUENCER_Halt_In,
  output logic [MICRO_SEQUENCER_ADDR-1:0] MICRO_SEQUENCER_CSAddress_OutBus,
  output logic                            MICRO_SEQUENCER_MemReq_Out,
  output logic                            MICRO_SEQUENCER_Stall_Out,
  output logic                            MICRO_SEQUENCER_Fault_Out,
  output logic [1:0]                      MICRO_SEQUENCER_State_OutBus
);

  localparam logic [1:0] RUN     = 2'b00;
  localparam logic [1:0] MEMWAIT = 2'b01;
  localparam logic [1:0] HALT    = 2'b10;
  localparam logic [1:0] FAULT   = 2'b11;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MICRO_SEQUENCER_TIMEOUT - 1);

  logic [1:0]                      state;
  logic [MICRO_SEQUENCER_ADDR-1:0] microPc;
  logic [MICRO_SEQUENCER_ADDR-1:0] nextAddr;
  logic [7:0]                      waitCnt;
  logic                            memReq;
  logic                            fault;
  logic                            access;
  logic                            stall;

  assign access = MICRO_SEQUENCER_MemRd_In | MICRO_SEQUENCER_MemWr_In;

  // Reserved branch type 11 behaves as a plain increment.
  always_comb begin
    nextAddr = microPc + 1'b1;
    case (MICRO_SEQUENCER_Tipo_InBus)
      2'b01:   nextAddr = MICRO_SEQUENCER_JumpAddr_InBus;
      2'b10:   nextAddr = {1'b1, MICRO_SEQUENCER_Op_InBus, MICRO_SEQUENCER_Op3_InBus, 2'b00};
      default: nextAddr = microPc + 1'b1;
    endcase
  end

  always_comb begin
    stall = 1'b1;
    case (state)
      RUN:     stall = access | MICRO_SEQUENCER_Halt_In;
      MEMWAIT: stall = ~MICRO_SEQUENCER_MemAck_In;
      default: stall = 1'b1;
    endcase
  end

  always_ff @(posedge MICRO_SEQUENCER_CLOCK_50) begin
    if (!MICRO_SEQUENCER_ResetInLow_In) begin
      state   <= RUN;
      microPc <= '0;
      waitCnt <= '0;
      memReq  <= 1'b0;
      fault   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (access) begin
            state   <= MEMWAIT;
            memReq  <= 1'b1;
            waitCnt <= '0;
          end else if (MICRO_SEQUENCER_Halt_In) begin
            state <= HALT;
          end else begin
            microPc <= nextAddr;
          end
        end
        MEMWAIT: begin
          // Ack takes precedence over a timeout landing in the same cycle.
          if (MICRO_SEQUENCER_MemAck_In) begin
            microPc <= nextAddr;
            state   <= RUN;
            memReq  <= 1'b0;
          end else if (waitCnt == TIMEOUT_LAST) begin
            microPc <= MICRO_SEQUENCER_FAULT_ADDR;
            fault   <= 1'b1;
            memReq  <= 1'b0;
            state   <= FAULT;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        HALT: begin
          if (!MICRO_SEQUENCER_Halt_In) state <= RUN;
        end
        default: begin
          state <= FAULT;
        end
      endcase
    end
  end

  assign MICRO_SEQUENCER_CSAddress_OutBus = microPc;
  assign MICRO_SEQUENCER_MemReq_Out       = memReq;
  assign MICRO_SEQUENCER_Stall_Out        = stall;
  assign MICRO_SEQUENCER_Fault_Out        = fault;
  assign MICRO_SEQUENCER_State_OutBus     = state;

endmodule
